pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SEG, default 8, bits added per pipeline stage; N = WIDTH/SEG stages.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have ports A and B, input, WIDTH, operands.
REQ-006 SHALL have port Invert_B, input, 1, per-transaction select that XORs every B bit (subtract when C_in=1).
REQ-007 SHALL have port C_in, input, 1, carry into bit 0.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the input handshake.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the output handshake.
REQ-010 SHALL have port flush, input, 1, synchronous pipeline discard.
REQ-011 SHALL have ports Sum (output, WIDTH) and C_out (output, 1), the result.
REQ-012 SHALL have port busy, output, 1, high when any stage holds a valid transaction.

Function
REQ-013 SHALL compute {C_out,Sum} = A + (B ^ {WIDTH{Invert_B}}) + C_in, exact to WIDTH+1 bits.
REQ-014 SHALL fail elaboration when WIDTH % SEG != 0 or SEG < 1.
REQ-015 SHALL add segment i (bits i*SEG+SEG-1 : i*SEG) in stage i, using the carry registered by stage i-1 (C_in for stage 0); unprocessed operand bits and completed sum bits travel with the transaction.
REQ-016 SHALL register a transfer on any edge where valid and ready are both high on the same interface.
REQ-017 SHALL make each stage i load when ready_i = !valid_i || ready_{i+1}, with ready_N = out_ready; in_ready = ready_0, combinational from out_ready.
REQ-018 SHALL, without stalls, raise out_valid for a transaction N cycles after its input transfer edge, sustaining one result per cycle.
REQ-019 SHALL hold Sum, C_out and any flag outputs stable while out_valid=1 and out_ready=0.
REQ-020 SHALL keep in_ready=0 when all N stages are valid and out_ready=0.
REQ-021 SHALL, on an edge with flush=1, clear all stage valid bits; an input offered in the same cycle is discarded and does not transfer.
REQ-022 SHALL keep data registers unchanged in a stage that does not load; only valid bits need reset.
REQ-023 SHALL drive busy = OR of all stage valid bits.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force all stage valid bits to 0, out_valid=0, busy=0, Sum=0, C_out=0 and any flag outputs to 0.
REQ-025 SHALL discard in-flight transactions on reset mid-operation; no result for them appears after release.
REQ-026 SHALL accept a transfer on the first rising edge after rst_n deasserts, with in_ready=1 (no stages valid).

Configuration
REQ-027 SHALL, with macro PIPELINED_ADDER_FLAGS_EN defined, add outputs Zero, Negative and Overflow (each 1 bit), registered alongside Sum. Zero = (Sum==0). Negative = Sum[WIDTH-1]. Overflow = signed overflow of the effective two's-complement add.
REQ-028 SHALL, without PIPELINED_ADDER_FLAGS_EN, omit these ports and their logic entirely.

Verification (WIDTH=32, SEG=8, N=4)
REQ-029 SHALL cover wrap: A=0xFFFFFFFF, B=1, Invert_B=0, C_in=0, out_ready=1 -> out_valid at edge 4, Sum=0x00000000, C_out=1 (Zero=1 with flags).
REQ-030 SHALL cover subtract: A=5, B=7, Invert_B=1, C_in=1 -> Sum=0xFFFFFFFE, C_out=0 (Negative=1, Overflow=0).
REQ-031 SHALL cover streaming: 4 back-to-back transfers (1+1, 2+2, 3+3, 4+4) -> results 2, 4, 6, 8 on 4 consecutive cycles, in order.
REQ-032 SHALL cover stall: out_ready=0 with 5 offered transfers -> 4 accepted; in_ready=0; Sum held at first result; after out_ready=1 all 4 drain in order, then the fifth is accepted.
REQ-033 SHALL cover flush and reset: flush=1 with 2 in flight plus in_valid=1 -> busy=0 next cycle, no out_valid; rst_n=0 mid-stream -> outputs 0 immediately, no stale results after release.
REQ-034 SHALL cover flags: A=0x7FFFFFFF, B=1, add -> Sum=0x80000000, Overflow=1, Negative=1, C_out=0.

Source files
------------

// File: rtl/pipelined_adder.sv
// Segmented ripple adder: stage i adds bits [i*SEG +: SEG] with valid/ready flow control per stage.
// Define PIPELINED_ADDER_FLAGS_EN to add registered Zero/Negative/Overflow outputs.
module pipelined_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Invert_B,
    input  logic             C_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] Sum,
    output logic             C_out,
    output logic             busy
`ifdef PIPELINED_ADDER_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Negative,
    output logic             Overflow
`endif
);

    localparam int          SEG_SAFE = (SEG < 1) ? 1 : SEG;
    localparam int unsigned N        = WIDTH / SEG_SAFE;

    generate
        if (SEG < 1 || (WIDTH % SEG_SAFE) != 0) begin : g_bad_cfg
            $error("pipelined_adder: WIDTH must be a positive multiple of SEG");
        end
    endgenerate

    logic [N-1:0]     valid_q, valid_d;
    logic [N-1:0]     carry_q, carry_d;
    logic [N-1:0]     ready;
    logic [WIDTH-1:0] a_q   [N];
    logic [WIDTH-1:0] a_d   [N];
    logic [WIDTH-1:0] b_q   [N];
    logic [WIDTH-1:0] b_d   [N];
    logic [WIDTH-1:0] sum_q [N];
    logic [WIDTH-1:0] sum_d [N];
`ifdef PIPELINED_ADDER_FLAGS_EN
    logic zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
`endif

    // ready_i = !valid_i || ready_{i+1} unrolled, so no vector feeds back on itself
    always_comb begin
        logic r;
        ready = '0;
        r     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            r = out_ready;
            for (int unsigned j = i; j < N; j++) begin
                r = r | ~valid_q[j];
            end
            ready[i] = r;
        end
    end

    always_comb begin
        logic [WIDTH-1:0] a_s, b_s, s_s;
        logic             c_s, v_s;
        logic [SEG:0]     seg_sum;
        int unsigned      prev;
        valid_d = valid_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
`ifdef PIPELINED_ADDER_FLAGS_EN
        zero_d  = zero_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
`endif
        a_s     = '0;
        b_s     = '0;
        s_s     = '0;
        c_s     = 1'b0;
        v_s     = 1'b0;
        seg_sum = '0;
        prev    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            prev = (i == 0) ? 0 : i - 1;
            if (i == 0) begin
                a_s = A;
                b_s = B ^ {WIDTH{Invert_B}};
                s_s = '0;
                c_s = C_in;
                v_s = in_valid;
            end else begin
                a_s = a_q[prev];
                b_s = b_q[prev];
                s_s = sum_q[prev];
                c_s = carry_q[prev];
                v_s = valid_q[prev];
            end
            seg_sum = {1'b0, a_s[i*SEG_SAFE +: SEG_SAFE]} + {1'b0, b_s[i*SEG_SAFE +: SEG_SAFE]}
                    + {{SEG_SAFE{1'b0}}, c_s};
            s_s[i*SEG_SAFE +: SEG_SAFE] = seg_sum[SEG_SAFE-1:0];
            if (ready[i]) begin
                valid_d[i] = v_s;
                if (v_s && !flush) begin
                    a_d[i]     = a_s;
                    b_d[i]     = b_s;
                    sum_d[i]   = s_s;
                    carry_d[i] = seg_sum[SEG_SAFE];
`ifdef PIPELINED_ADDER_FLAGS_EN
                    if (i == N - 1) begin
                        zero_d = (s_s == '0);
                        neg_d  = s_s[WIDTH-1];
                        ovf_d  = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (s_s[WIDTH-1] != a_s[WIDTH-1]);
                    end
`endif
                end
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                sum_q[i] <= '0;
            end
`ifdef PIPELINED_ADDER_FLAGS_EN
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
`ifdef PIPELINED_ADDER_FLAGS_EN
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[N-1];
    assign busy      = |valid_q;
    assign Sum       = sum_q[N-1];
    assign C_out     = carry_q[N-1];
`ifdef PIPELINED_ADDER_FLAGS_EN
    assign Zero      = zero_q;
    assign Negative  = neg_q;
    assign Overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed scoreboard bench for pipelined_adder (WIDTH=32, SEG=8, four stages).
module tb_pipelined_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] A, B;
    logic        Invert_B, C_in;
    logic        in_valid, in_ready;
    logic        out_valid, out_ready;
    logic        flush;
    logic [31:0] Sum;
    logic        C_out, busy;
`ifdef PIPELINED_ADDER_FLAGS_EN
    logic        Zero, Negative, Overflow;
`endif

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic last_acc;

    pipelined_adder #(.WIDTH(32), .SEG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Invert_B  (Invert_B),
        .C_in      (C_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .Sum       (Sum),
        .C_out     (C_out),
        .busy      (busy)
`ifdef PIPELINED_ADDER_FLAGS_EN
        ,
        .Zero      (Zero),
        .Negative  (Negative),
        .Overflow  (Overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic inv, input logic cin);
        exp_t        e;
        logic [31:0] be;
        logic [32:0] r;
        longint      sr;
        be     = inv ? ~b : b;
        r      = {1'b0, a} + {1'b0, be} + {32'd0, cin};
        sr     = longint'($signed(a)) + longint'($signed(be)) + longint'(cin);
        e.sum  = r[31:0];
        e.cout = r[32];
        e.z    = (r[31:0] == 32'd0);
        e.n    = r[31];
        e.v    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic inv, input logic cin);
        A        = a;
        B        = b;
        Invert_B = inv;
        C_in     = cin;
    endtask

    // Called at a falling edge; samples both handshakes, then advances to the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        last_acc = in_valid && in_ready && !flush;
        if (out_valid && out_ready) begin
            n_assert++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_out: observed Sum 0x%0h expected no output", Sum);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sum", Sum, e.sum);
                check("c_out", C_out, e.cout);
`ifdef PIPELINED_ADDER_FLAGS_EN
                check("zero", Zero, e.z);
                check("negative", Negative, e.n);
                check("overflow", Overflow, e.v);
`endif
            end
        end
        if (last_acc) sb.push_back(model(A, B, Invert_B, C_in));
        if (flush) sb.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic inv, input logic cin);
        drive(a, b, inv, cin);
        in_valid = 1'b1;
        tick();
        check("send_acc", last_acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int edges;
        int acc;
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", Sum, 32'd0);
        check("rst_c_out", C_out, 1'b0);
`ifdef PIPELINED_ADDER_FLAGS_EN
        check("rst_flags", {Zero, Negative, Overflow}, 3'b000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // wrap: transfer edge counts as edge 1, result visible after edge 4
        drive(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        check("wrap_acc", last_acc, 1'b1);
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 16) begin
            tick();
            edges++;
        end
        check("wrap_latency", edges, 4);
        drain();

        send(32'd5, 32'd7, 1'b1, 1'b1);
        drain();
        send(32'd0, 32'd0, 1'b1, 1'b1);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        send(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        drain();

        // streaming: four results on four consecutive cycles
        for (int k = 1; k <= 4; k++) begin
            drive(k, k, 1'b0, 1'b0);
            in_valid = 1'b1;
            tick();
            check("stream_acc", last_acc, 1'b1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("stream_valid", out_valid, 1'b1);
            tick();
        end
        check("stream_empty", sb.size(), 0);

        // stall: only four fit, head result held
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            drive(10 + acc, 10 + acc, 1'b0, 1'b0);
            in_valid = 1'b1;
            tick();
            if (last_acc) acc++;
            if (out_valid) begin
                check("stall_hold_sum", Sum, 32'd20);
                check("stall_hold_cout", C_out, 1'b0);
            end
        end
        check("stall_accepted", acc, 4);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        guard = 0;
        while (acc < 5 && guard < 20) begin
            drive(10 + acc, 10 + acc, 1'b0, 1'b0);
            tick();
            if (last_acc) acc++;
            guard++;
        end
        check("stall_fifth", acc, 5);
        in_valid = 1'b0;
        drain();

        // flush with two in flight and a third offered
        drive(32'd100, 32'd1, 1'b0, 1'b0);
        in_valid = 1'b1;
        tick();
        drive(32'd200, 32'd1, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        drive(32'd300, 32'd1, 1'b0, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check("flush_no_out", out_valid, 1'b0);
        end

        // asynchronous reset mid-stream
        for (int k = 0; k < 3; k++) begin
            drive(32'd1000 + k, 32'd3, 1'b0, 1'b0);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_sum", Sum, 32'd0);
        check("midrst_c_out", C_out, 1'b0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("midrst_no_stale", out_valid, 1'b0);
        end

        // random traffic with random back-pressure
        acc = 0;
        guard = 0;
        while (acc < 12 && guard < 300) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            in_valid  = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (last_acc) acc++;
            guard++;
        end
        check("rand_accepted", acc, 12);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
